fifo_read_streamer: RTL and testbench

Read-side engine for the synchronous FIFO: pops words whenever the FIFO is non-empty, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the data as a valid/ready stream to downstream logic. It sits between the FIFO read interface (`rd_en`/`rdata`/`empty`/`rd_error`) and any consumer that may stall. It sustains one word per clock when the consumer never stalls. It never issues a read to an empty FIFO and never drops or reorders data.

---
 rtl/fifo_read_streamer_if.sv | 33 +++
 rtl/fifo_read_streamer.sv | 71 +++++++
 tb/tb_fifo_read_streamer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_streamer_if.sv
// Bundles the FIFO read port and the downstream valid/ready stream of the read streamer.
// Stream handshake: a word moves when m_valid_o && m_ready_i on a rising edge; m_data_o holds while valid && !ready.
interface fifo_read_streamer_if #(
   parameter int WIDTH = 8
);
   logic             fifo_rd_en_o;
   logic [WIDTH-1:0] fifo_rdata_i;
   logic             fifo_empty_i;
   logic             fifo_rd_error_i;
   logic             m_valid_o;
   logic [WIDTH-1:0] m_data_o;
   logic             m_ready_i;

   modport master (
      output fifo_rd_en_o,
      input  fifo_rdata_i,
      input  fifo_empty_i,
      input  fifo_rd_error_i,
      output m_valid_o,
      output m_data_o,
      input  m_ready_i
   );

   modport slave (
      input  fifo_rd_en_o,
      output fifo_rdata_i,
      output fifo_empty_i,
      output fifo_rd_error_i,
      input  m_valid_o,
      input  m_data_o,
      output m_ready_i
   );
endinterface

// File: rtl/fifo_read_streamer.sv
// Pops a synchronous FIFO whenever it is non-empty and re-times its one-cycle read latency
// through a 2-entry buffer into a valid/ready stream.
module fifo_read_streamer #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   fifo_read_streamer_if.master bus,
   output logic [CNT_WIDTH-1:0] pop_count_o,
   output logic                 err_o
);

   logic [WIDTH-1:0]     mem_q [2];
   logic [1:0]           occ_q;
   logic                 infl_q;
   logic                 wr_ptr_q;
   logic                 rd_ptr_q;
   logic [CNT_WIDTH-1:0] pop_count_q;
   logic                 err_q;

   logic                 pop;
   logic                 rd_en;
   logic [2:0]           occ_next;

   // occ_next already accounts for the in-flight word, so issuing only while it is
   // below 2 leaves room for the word this read will return next cycle.
   always_comb begin
      pop      = (occ_q != 2'd0) && bus.m_ready_i;
      occ_next = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
      rd_en    = !rst_i && en_i && !bus.fifo_empty_i && (occ_next < 3'd2);
   end

   assign bus.fifo_rd_en_o = rd_en;
   assign bus.m_valid_o    = (occ_q != 2'd0);
   assign bus.m_data_o     = mem_q[rd_ptr_q];
   assign pop_count_o      = pop_count_q;
   assign err_o            = err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         occ_q       <= 2'd0;
         infl_q      <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         pop_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         infl_q <= rd_en;
         if (infl_q) begin
            mem_q[wr_ptr_q] <= bus.fifo_rdata_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_next[1:0];
         if (rd_en) begin
            pop_count_q <= pop_count_q + 1'b1;
         end
         // Overflow can only happen if the issue rule is broken; flag it rather than hide it.
         if (bus.fifo_rd_error_i || (occ_next > 3'd2)) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Bench for fifo_read_streamer: a queue-based FIFO model feeds the DUT, and a scoreboard
// checks stream order, stall stability, read-count, occupancy bound and sticky error.
module tb_fifo_read_streamer;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic ready = 1'b0;
   logic rd_error = 1'b0;
   logic fifo_empty = 1'b1;
   logic [W-1:0] fifo_rdata = '0;
   logic [15:0] pop_count;
   logic [3:0] pop_count4;
   logic err;
   logic err4;

   fifo_read_streamer_if #(.WIDTH(W)) ifc ();
   fifo_read_streamer_if #(.WIDTH(W)) ifc4 ();

   assign ifc.fifo_rdata_i     = fifo_rdata;
   assign ifc.fifo_empty_i     = fifo_empty;
   assign ifc.fifo_rd_error_i  = rd_error;
   assign ifc.m_ready_i        = ready;
   assign ifc4.fifo_rdata_i    = fifo_rdata;
   assign ifc4.fifo_empty_i    = fifo_empty;
   assign ifc4.fifo_rd_error_i = rd_error;
   assign ifc4.m_ready_i       = ready;

   fifo_read_streamer #(.WIDTH(W), .CNT_WIDTH(16)) u_dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .bus(ifc.master),
      .pop_count_o(pop_count), .err_o(err)
   );

   fifo_read_streamer #(.WIDTH(W), .CNT_WIDTH(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .bus(ifc4.master),
      .pop_count_o(pop_count4), .err_o(err4)
   );

   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail = 0;
   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];
   logic s_rd = 1'b0;
   logic [W-1:0] s_word = '0;
   logic s_empty = 1'b1;
   int reads = 0;
   int xfers = 0;
   int cyc = 0;
   logic err_exp = 1'b0;
   logic prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;
   int rd_cnt, first_rd, last_rd, v_cnt, first_v, last_v;

   // FIFO model: a read decided in cycle N returns its word during cycle N+1.
   always @(posedge clk) begin
      if (s_rd) fifo_rdata <= s_word;
      fifo_empty <= s_empty;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_metrics();
      rd_cnt = 0; first_rd = -1; last_rd = -1;
      v_cnt = 0; first_v = -1; last_v = -1;
   endtask

   task automatic load(input int n);
      logic [W-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = 8'($urandom_range(0, 255));
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
   endtask

   // Observes one cycle at the falling edge and advances the reference model.
   task automatic observe();
      logic rd, v;
      logic [W-1:0] d, e;
      rd = ifc.fifo_rd_en_o;
      v  = ifc.m_valid_o;
      d  = ifc.m_data_o;
      check("rd_when_empty", 32'(rd && fifo_empty), 32'd0);
      if (rst) check("rd_in_reset", 32'(rd), 32'd0);
      check("pop_count", 32'(pop_count), 32'(reads & 32'hFFFF));
      check("pop_count4", 32'(pop_count4), 32'(reads % 16));
      check("err", 32'(err), 32'(err_exp));
      check("err4", 32'(err4), 32'(err_exp));
      check("occupancy_le2", 32'((reads - xfers) <= 2), 32'd1);
      if (prev_stall) begin
         check("stall_valid", 32'(v), 32'd1);
         check("stall_data", 32'(d), 32'(prev_data));
      end
      if (v && ready && !rst) begin
         check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("data_order", 32'(d), 32'(e));
         end
         xfers++;
      end
      s_rd = rd;
      if (rd) begin
         s_word = (fifo_q.size() != 0) ? fifo_q.pop_front() : '0;
         reads++;
         rd_cnt++;
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
      end
      if (v) begin
         v_cnt++;
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
      end
      prev_stall = v && !ready;
      prev_data  = d;
      if (rst) begin
         reads = 0;
         xfers = 0;
         exp_q = fifo_q;
         err_exp = 1'b0;
         prev_stall = 1'b0;
      end else if (rd_error) begin
         err_exp = 1'b1;
      end
      s_empty = (fifo_q.size() == 0);
      cyc++;
   endtask

   task automatic settle();
      @(negedge clk);
      observe();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      settle();
      advance();
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      en = 1'b1;
      ready = 1'b1;
      while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < max_cyc) begin
         tick();
         n++;
      end
      check("drain_done", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_r, base_x, n;
      logic [W-1:0] w0;
      clear_metrics();

      // Reset state
      advance();
      advance();
      settle();
      check("rst_valid", 32'(ifc.m_valid_o), 32'd0);
      check("rst_data", 32'(ifc.m_data_o), 32'd0);
      check("rst_pop", 32'(pop_count), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rd_en", 32'(ifc.fifo_rd_en_o), 32'd0);
      advance();
      rst = 1'b0;

      // Burst, no stall
      ready = 1'b1;
      load(16);
      tick();
      clear_metrics();
      en = 1'b1;
      drain(60);
      check("burst_rd_cnt", 32'(rd_cnt), 32'd16);
      check("burst_rd_run", 32'(last_rd - first_rd + 1), 32'd16);
      check("burst_v_cnt", 32'(v_cnt), 32'd16);
      check("burst_v_run", 32'(last_v - first_v + 1), 32'd16);
      check("burst_v_latency", 32'(first_v - first_rd), 32'd2);
      check("burst_pop", 32'(pop_count), 32'd16);
      check("burst_err", 32'(err), 32'd0);

      // Back-pressure
      en = 1'b1;
      ready = 1'b0;
      base_r = reads;
      base_x = xfers;
      load(8);
      w0 = exp_q[0];
      repeat (11) tick();
      check("bp_pop", 32'(pop_count), 32'(base_r + 2));
      check("bp_valid", 32'(ifc.m_valid_o), 32'd1);
      check("bp_hold", 32'(ifc.m_data_o), 32'(w0));
      drain(60);
      check("bp_xfers", 32'(xfers - base_x), 32'd8);

      // Alternating ready
      base_x = xfers;
      load(16);
      en = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 120) begin
         ready = ~ready;
         tick();
         n++;
      end
      check("alt_xfers", 32'(xfers - base_x), 32'd16);
      check("alt_err", 32'(err), 32'd0);

      // Enable drop after 5 reads
      en = 1'b0;
      ready = 1'b1;
      load(10);
      tick();
      base_r = reads;
      base_x = xfers;
      en = 1'b1;
      n = 0;
      while ((reads - base_r) < 5 && n < 50) begin
         tick();
         n++;
      end
      en = 1'b0;
      repeat (10) tick();
      check("endrop_pop", 32'(pop_count), 32'(base_r + 5));
      check("endrop_xfers", 32'(xfers - base_x), 32'd5);
      drain(60);
      check("endrop_total", 32'(xfers - base_x), 32'd10);

      // Reset mid-stream with two words buffered
      en = 1'b1;
      ready = 1'b0;
      load(6);
      repeat (6) tick();
      check("pre_rst_valid", 32'(ifc.m_valid_o), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check("post_rst_valid", 32'(ifc.m_valid_o), 32'd0);
      check("post_rst_pop", 32'(pop_count), 32'd0);
      check("post_rst_data", 32'(ifc.m_data_o), 32'd0);
      advance();
      drain(60);

      // Sticky error
      rd_error = 1'b1;
      tick();
      rd_error = 1'b0;
      repeat (5) tick();
      check("err_sticky", 32'(err), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("err_cleared", 32'(err), 32'd0);

      // Counter wrap on the 4-bit instance
      en = 1'b0;
      ready = 1'b1;
      load(17);
      tick();
      drain(80);
      check("wrap_pop4", 32'(pop_count4), 32'd1);
      check("wrap_pop16", 32'(pop_count), 32'd17);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 3) != 0);
         ready = ($urandom_range(0, 1) != 0);
         if ($urandom_range(0, 5) == 0 && fifo_q.size() < 20) load($urandom_range(1, 4));
         tick();
      end
      drain(200);
      check("final_err", 32'(err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
